// File: rtl/sw_pkg.sv
//------------------------------------------------------------------------------
// Module   : sw_pkg
// Purpose  : Shared defaults and read-FSM state encoding for query_seq_buf.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sw_pkg;

  localparam int unsigned SW_DATA_W = 128;
  localparam int unsigned SW_ADDR_W = 10;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_FETCH  = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_t;

endpackage : sw_pkg

`default_nettype wire

// File: rtl/sdp_bram.sv
//------------------------------------------------------------------------------
// Module   : sdp_bram
// Purpose  : Simple dual-port RAM, one write port, one registered read port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sdp_bram
  import sw_pkg::*;
#(
  parameter int WIDTH   = SW_DATA_W,
  parameter int DEPTH_W = SW_ADDR_W + 1
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [DEPTH_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]   i_wdata,
  input  logic               i_re,
  input  logic [DEPTH_W-1:0] i_raddr,
  output logic [WIDTH-1:0]   o_rdata
);

  logic [WIDTH-1:0] r_mem [0:(1<<DEPTH_W)-1];
  logic [WIDTH-1:0] r_rdata;

  // No reset on the array or the output register so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : sdp_bram

`default_nettype wire

// File: rtl/query_seq_buf.sv
//------------------------------------------------------------------------------
// Module   : query_seq_buf
// Purpose  : Ping-pong query buffer: writer fills one bank while the reader
//            streams (and optionally replays) the oldest full bank.
// Options  : QSB_PARITY_EN - store and check one even-parity bit per word.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module query_seq_buf
  import sw_pkg::*;
#(
  parameter int DATA_W = SW_DATA_W,
  parameter int ADDR_W = SW_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic              rd_start,
  input  logic              rd_keep,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              rd_busy,
  output logic [1:0]        bank_full,
  output logic              overflow,
  output logic              parity_err
);

`ifdef QSB_PARITY_EN
  localparam int c_MEM_W = DATA_W + 1;
`else
  localparam int c_MEM_W = DATA_W;
`endif

  localparam logic [ADDR_W-1:0] c_ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] c_ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   c_LEN_ONE  = 1;

  // Writer state
  logic              r_wr_bank;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W:0]   r_len [2];
  logic [1:0]        r_full;
  logic              r_overflow;

  // Reader state
  rd_state_t         r_state;
  logic              r_rd_bank;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_keep;
  logic              r_rd_valid;
  logic              r_rd_last;
  logic              r_rd_busy;

  logic              w_wr_fire;
  logic              w_wr_end;
  logic              w_rd_fire;
  logic              w_rd_done;
  logic [ADDR_W:0]   w_cur_len;
  logic [ADDR_W-1:0] w_next_addr;
  logic [1:0]        w_full_set;
  logic [1:0]        w_full_clr;
  logic              w_re;
  logic [ADDR_W-1:0] w_raddr_lo;
  logic [c_MEM_W-1:0] w_mem_wdata;
  logic [c_MEM_W-1:0] w_mem_rdata;

  assign w_wr_fire   = wr_valid & ~r_full[r_wr_bank];
  assign w_wr_end    = wr_last | (r_wr_addr == c_ADDR_MAX);
  assign w_rd_fire   = r_rd_valid & rd_ready;
  assign w_rd_done   = w_rd_fire & r_rd_last;
  assign w_cur_len   = r_len[r_rd_bank];
  assign w_next_addr = r_rd_addr + c_ADDR_ONE;

  //--------------------------------------------------------------------------
  // Writer
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank  <= 1'b0;
      r_wr_addr  <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_len[i] <= '0;
      end
    end else if (w_wr_fire) begin
      if (w_wr_end) begin
        r_len[r_wr_bank] <= {1'b0, r_wr_addr} + c_LEN_ONE;
        r_wr_bank        <= ~r_wr_bank;
        r_wr_addr        <= '0;
        if (!wr_last) begin
          r_overflow <= 1'b1;
        end
      end else begin
        r_wr_addr <= r_wr_addr + c_ADDR_ONE;
      end
    end
  end

  // Writer and reader always touch different banks, so set and clear merge.
  always_comb begin
    w_full_set = 2'b00;
    w_full_clr = 2'b00;
    if (w_wr_fire && w_wr_end) begin
      w_full_set[r_wr_bank] = 1'b1;
    end
    if (w_rd_done && !r_keep) begin
      w_full_clr[r_rd_bank] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 2'b00;
    end else begin
      r_full <= (r_full & ~w_full_clr) | w_full_set;
    end
  end

  //--------------------------------------------------------------------------
  // Reader FSM
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RD_IDLE;
      r_rd_bank  <= 1'b0;
      r_rd_addr  <= '0;
      r_keep     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_busy  <= 1'b0;
    end else begin
      case (r_state)
        RD_IDLE: begin
          if (rd_start && r_full[r_rd_bank]) begin
            r_state   <= RD_FETCH;
            r_keep    <= rd_keep;
            r_rd_busy <= 1'b1;
            r_rd_addr <= '0;
          end
        end
        RD_FETCH: begin
          r_state    <= RD_STREAM;
          r_rd_valid <= 1'b1;
          r_rd_last  <= (w_cur_len == c_LEN_ONE);
        end
        RD_STREAM: begin
          if (w_rd_fire) begin
            if (r_rd_last) begin
              r_state    <= RD_IDLE;
              r_rd_valid <= 1'b0;
              r_rd_last  <= 1'b0;
              r_rd_busy  <= 1'b0;
              if (!r_keep) begin
                r_rd_bank <= ~r_rd_bank;
              end
            end else begin
              r_rd_addr <= w_next_addr;
              r_rd_last <= (({1'b0, w_next_addr} + c_LEN_ONE) == w_cur_len);
            end
          end
        end
        default: begin
          r_state <= RD_IDLE;
        end
      endcase
    end
  end

  // The RAM output register doubles as the output stage: it only advances on
  // an accepted word, which keeps data stable through stalls without bubbles.
  always_comb begin
    w_re       = 1'b0;
    w_raddr_lo = '0;
    if (r_state == RD_FETCH) begin
      w_re = 1'b1;
    end else if (r_state == RD_STREAM && w_rd_fire && !r_rd_last) begin
      w_re       = 1'b1;
      w_raddr_lo = w_next_addr;
    end
  end

  //--------------------------------------------------------------------------
  // Storage and optional parity
  //--------------------------------------------------------------------------
`ifdef QSB_PARITY_EN
  logic r_parity_err;

  assign w_mem_wdata = {^wr_data, wr_data};
  assign rd_data     = w_mem_rdata[DATA_W-1:0];

  // Even parity over data plus stored bit must reduce to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
    end else if (w_rd_fire && (^w_mem_rdata)) begin
      r_parity_err <= 1'b1;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign w_mem_wdata = wr_data;
  assign rd_data     = w_mem_rdata;
  assign parity_err  = 1'b0;
`endif

  sdp_bram #(
    .WIDTH   (c_MEM_W),
    .DEPTH_W (ADDR_W + 1)
  ) u_bram (
    .clk     (clk),
    .i_we    (w_wr_fire),
    .i_waddr ({r_wr_bank, r_wr_addr}),
    .i_wdata (w_mem_wdata),
    .i_re    (w_re),
    .i_raddr ({r_rd_bank, w_raddr_lo}),
    .o_rdata (w_mem_rdata)
  );

  assign wr_ready  = ~r_full[r_wr_bank];
  assign rd_valid  = r_rd_valid;
  assign rd_last   = r_rd_last;
  assign rd_busy   = r_rd_busy;
  assign bank_full = r_full;
  assign overflow  = r_overflow;

endmodule : query_seq_buf

`default_nettype wire

// File: tb/tb_query_seq_buf.sv
//------------------------------------------------------------------------------
// Module   : tb_query_seq_buf
// Purpose  : Directed plus randomized bench for query_seq_buf (QSB_PARITY_EN aware).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_query_seq_buf;

  localparam int DW   = 32;
  localparam int AW   = 3;
  localparam int MAXW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          wr_last = 1'b0;
  logic          rd_start = 1'b0;
  logic          rd_keep = 1'b0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          rd_busy;
  logic [1:0]    bank_full;
  logic          overflow;
  logic          parity_err;

  always #5 clk = ~clk;

  query_seq_buf #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .rd_start   (rd_start),
    .rd_keep    (rd_keep),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .rd_busy    (rd_busy),
    .bank_full  (bank_full),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: FIFO of up to two completed queries, oldest in slot 0.
  // The oldest query's bank index flips each time a query is consumed.
  logic [DW-1:0] pq_data [2][MAXW];
  int            pq_len [2];
  int            pq_cnt = 0;
  bit            hb = 1'b0;
  bit            m_ovf = 1'b0;
  logic [DW-1:0] wbuf [MAXW];

  function automatic logic [1:0] exp_full();
    if (pq_cnt == 0) return 2'b00;
    if (pq_cnt == 1) return hb ? 2'b10 : 2'b01;
    return 2'b11;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i < len; i++) wbuf[i] = $urandom;
  endtask

  task automatic write_query(input int len, input bit implicit_end);
    for (int i = 0; i < len; i++) begin
      wr_valid = 1'b1;
      wr_data  = wbuf[i];
      wr_last  = (!implicit_end && i == len - 1);
      @(negedge clk);
      check("wr_ready_during_write", wr_ready, 1);
      tick();
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    for (int i = 0; i < len; i++) pq_data[pq_cnt][i] = wbuf[i];
    pq_len[pq_cnt] = len;
    pq_cnt++;
    if (implicit_end) m_ovf = 1'b1;
  endtask

  task automatic pop_model(input bit keep);
    if (!keep) begin
      for (int i = 0; i < MAXW; i++) pq_data[0][i] = pq_data[1][i];
      pq_len[0] = pq_len[1];
      pq_cnt--;
      hb = ~hb;
    end
  endtask

  // mode 0: rd_ready always high, 1: fixed 1,0,0,1,1,0,1 pattern, 2: random
  task automatic stream(input bit keep, input int mode);
    int            idx = 0;
    int            c = 0;
    int            first = -1;
    int            len = pq_len[0];
    bit            stall = 1'b0;
    bit            done = 1'b0;
    logic [DW-1:0] held = '0;
    logic          held_last = 1'b0;
    bit            pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    rd_start = 1'b1;
    rd_keep  = keep;
    while (!done && c < 200) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = pat[c % 7];
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (c == 1) check("rd_busy_after_start", rd_busy, 1);
      if (stall) begin
        check("stall_valid", rd_valid, 1);
        check("stall_data", rd_data, held);
        check("stall_last", rd_last, held_last);
      end
      stall = 1'b0;
      if (rd_valid === 1'b1) begin
        if (first < 0) begin
          first = c;
          check("first_valid_latency", c, 2);
        end
        if (rd_ready) begin
          check("rd_data", rd_data, pq_data[0][idx]);
          check("rd_last", rd_last, (idx == len - 1));
          idx++;
          done = (idx == len);
        end else begin
          stall     = 1'b1;
          held      = rd_data;
          held_last = rd_last;
        end
      end
      tick();
      rd_start = 1'b0;
      c++;
    end
    check("stream_completed", done, 1);
    rd_ready = 1'b0;
    pop_model(keep);
    @(negedge clk);
    check("rd_busy_after_last", rd_busy, 0);
    check("rd_valid_after_last", rd_valid, 0);
    check("bank_full_after_stream", bank_full, exp_full());
    check("wr_ready_after_stream", wr_ready, (pq_cnt < 2));
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pb;
    int len;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("reset_bank_full", bank_full, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_last", rd_last, 0);
    check("reset_rd_busy", rd_busy, 0);
    check("reset_overflow", overflow, 0);
    check("reset_parity_err", parity_err, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("wr_ready_after_reset", wr_ready, 1);
    tick();

    // Three-word query 1,2,3
    wbuf[0] = 32'h1; wbuf[1] = 32'h2; wbuf[2] = 32'h3;
    write_query(3, 1'b0);
    @(negedge clk);
    check("bank_full_one", bank_full, exp_full());
    tick();
    stream(1'b0, 0);

    // Both banks full, then drain
    fill_random(2); write_query(2, 1'b0);
    fill_random(4); write_query(4, 1'b0);
    @(negedge clk);
    check("wr_ready_both_full", wr_ready, 0);
    check("bank_full_both", bank_full, 2'b11);
    tick();
    stream(1'b0, 0);
    stream(1'b0, 1);

    // Implicit termination at the last address
    for (int i = 0; i < MAXW; i++) wbuf[i] = 32'hA0 + i;
    write_query(MAXW, 1'b1);
    @(negedge clk);
    check("overflow_set", overflow, 1);
    check("bank_full_overflow", bank_full, exp_full());
    tick();
    stream(1'b0, 2);
    @(negedge clk);
    check("overflow_sticky", overflow, m_ovf);
    tick();

    // Replay twice, then consume
    fill_random(5); write_query(5, 1'b0);
    stream(1'b1, 2);
    stream(1'b1, 0);
    stream(1'b0, 1);

    // Single-word query
    fill_random(1); write_query(1, 1'b0);
    stream(1'b0, 0);

    // rd_start with nothing buffered is ignored
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    @(negedge clk);
    check("empty_start_busy", rd_busy, 0);
    tick();
    @(negedge clk);
    check("empty_start_valid", rd_valid, 0);
    tick();

    // Randomized mix
    for (int it = 0; it < 24; it++) begin
      if (pq_cnt == 0 || (pq_cnt < 2 && $urandom_range(0, 1) == 1)) begin
        len = $urandom_range(1, MAXW);
        fill_random(len);
        write_query(len, (len == MAXW) && ($urandom_range(0, 1) == 1));
      end else begin
        stream(1'($urandom_range(0, 3) == 0), 2);
      end
    end
    while (pq_cnt > 0) stream(1'b0, 2);
    @(negedge clk);
    check("overflow_model", overflow, m_ovf);
    tick();

`ifdef QSB_PARITY_EN
    pb = (pq_cnt == 0) ? hb : ~hb;
    fill_random(2); write_query(2, 1'b0);
    dut.u_bram.r_mem[{pb, 3'd1}] = dut.u_bram.r_mem[{pb, 3'd1}] ^ 33'h8;
    pq_data[pq_cnt-1][1] = pq_data[pq_cnt-1][1] ^ 32'h8;
    @(negedge clk);
    check("parity_err_before", parity_err, 0);
    tick();
    stream(1'b0, 0);
    @(negedge clk);
    check("parity_err_set", parity_err, 1);
    tick();
`else
    pb = hb;
    @(negedge clk);
    check("parity_err_tied", parity_err, 0);
    tick();
`endif

    // Reset while streaming
    fill_random(6); write_query(6, 1'b0);
    rd_start = 1'b1; rd_keep = 1'b0; rd_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("midstream_valid", rd_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async_valid", rd_valid, 0);
    check("reset_async_busy", rd_busy, 0);
    check("reset_async_full", bank_full, 0);
    check("reset_async_parity", parity_err, 0);
    pq_cnt = 0; hb = 1'b0; m_ovf = 1'b0;
    rd_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("wr_ready_after_midreset", wr_ready, 1);
    check("overflow_after_midreset", overflow, 0);
    tick();

    // Buffer still works after reset
    fill_random(3); write_query(3, 1'b0);
    stream(1'b0, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_query_seq_buf

`default_nettype wire

// File: doc/query_seq_buf.md
QUERY_SEQ_BUF -- requirements
Module: query_seq_buf

Interface
REQ-001 Parameter DATA_W, default 128, SHALL set the width of a memory word.
REQ-002 Parameter ADDR_W, default 10, SHALL set words per bank to 2^ADDR_W.
REQ-003 clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset, asynchronous, active-low.
REQ-005 wr_valid / wr_ready  in / out  1 / 1  SHALL be the write handshake; a word transfers when both are high.
REQ-006 wr_data  input  DATA_W  SHALL carry the packed query word.
REQ-007 wr_last  input  1  SHALL mark the final word of a query.
REQ-008 rd_start  input  1  SHALL request streaming of the oldest full bank.
REQ-009 rd_keep  input  1  SHALL be sampled with rd_start; when high, the bank is retained after streaming (replay).
REQ-010 rd_valid / rd_ready  out / in  1 / 1  SHALL be the read handshake.
REQ-011 rd_data  output  DATA_W  SHALL carry the read word.
REQ-012 rd_last  output  1  SHALL flag the final word of the streamed query.
REQ-013 rd_busy  output  1  SHALL be high from rd_start acceptance until the rd_last transfer.
REQ-014 bank_full  output  2  SHALL show the full state of bank 0 and bank 1.
REQ-015 overflow  output  1  SHALL be a sticky flag for an implicitly terminated query.
REQ-016 parity_err  output  1  SHALL be a sticky read-parity error flag.

Function
REQ-017 Writer SHALL fill the write bank from address 0, incrementing once per transfer.
REQ-018 On a wr_last transfer, the writer SHALL record length = address+1, mark the bank full and toggle to the other bank.
REQ-019 wr_ready SHALL be low while the current write bank is full and high otherwise.
REQ-020 A transfer at address 2^ADDR_W-1 without wr_last SHALL be treated as last and SHALL set overflow.
REQ-021 Read FSM SHALL have states IDLE, FETCH and STREAM.
REQ-022 IDLE->FETCH SHALL occur on rd_start when the read bank is full; rd_start is ignored when the bank is empty or the FSM is not IDLE.
REQ-023 Memory read latency SHALL be 1 cycle, and the first rd_valid SHALL occur 2 cycles after rd_start is accepted.
REQ-024 In STREAM with rd_ready held high, one word per cycle SHALL be delivered with no bubbles.
REQ-025 While rd_valid is high and rd_ready is low, rd_data, rd_last and rd_valid SHALL remain stable; no words are lost or duplicated.
REQ-026 After the rd_last transfer: if rd_keep was low, the bank SHALL be cleared and the read bank toggled; if high, the bank SHALL stay full and the read bank unchanged. The FSM then returns to IDLE.
REQ-027 When the writer completes a bank in the same cycle the reader clears the other bank, both updates SHALL take effect.
REQ-028 A query of length 1 SHALL yield a single word with rd_valid and rd_last both high.

Reset
REQ-029 While rst_n is low: all bank_full bits, both bank selects, both addresses, rd_valid, rd_last, rd_busy, overflow and parity_err SHALL be 0, and the FSM SHALL be IDLE.
REQ-030 wr_ready SHALL be 1 from the first cycle after reset release.
REQ-031 Reset mid-query SHALL discard all queries; memory contents need not be cleared.

Configuration
REQ-032 With QSB_PARITY_EN defined, one even-parity bit per word SHALL be stored and checked on read; a mismatch on a rd_valid&rd_ready transfer sets parity_err.
REQ-033 Without QSB_PARITY_EN, no parity storage SHALL exist and parity_err SHALL be tied 0.

Structure
REQ-034 Package sw_pkg SHALL hold the DATA_W/ADDR_W defaults and the read-FSM state enum.
REQ-035 Sub-module sdp_bram (one write port, one registered read port, depth 2^(ADDR_W+1), bank = address MSB) SHALL be instantiated once.

Verification
REQ-036 Write 3 words 0x1,0x2,0x3 (last on 0x3), rd_start with rd_ready=1 -> rd_valid on cycles +2..+4, data 1,2,3, rd_last on 3, bank_full returns to 00.
REQ-037 Fill both banks (lengths 2 and 4) -> wr_ready=0, bank_full=11; stream bank 0 -> wr_ready=1 on the cycle after rd_last.
REQ-038 Stream 4 words with rd_ready toggling 1,0,0,1,1,0,1 -> exactly 4 transfers, in order, with data stable during stalls.
REQ-039 ADDR_W=3, write 8 words without last -> overflow=1, bank full, length 8; rd_last on the 8th word.
REQ-040 rd_start with rd_keep=1, stream twice -> identical 2 sequences, bank stays full; a third stream with rd_keep=0 clears it.
REQ-041 Assert rst_n=0 mid-stream -> rd_valid, rd_busy and bank_full go to 0 immediately; with QSB_PARITY_EN, a forced parity flip on a stored word -> parity_err=1 on that word's transfer.
